// File: rtl/growing_interp_signed_if.sv
// growing_interp_signed_if: sample-in / interpolated-sample-out bundle.
// The master drives samples in, and the slave (the interpolator) returns the output stream.
interface growing_interp_signed_if #(parameter int N = 16);
    logic                valid;
    logic signed [N-1:0] x;
    logic [7:0]          n_interp_in;
    logic                in_ready;
    logic                new_dat;
    logic signed [N-1:0] y;
    modport master (output valid, x, n_interp_in, input in_ready, new_dat, y);
    modport slave  (input valid, x, n_interp_in, output in_ready, new_dat, y);
endinterface

// File: rtl/growing_interp_signed.sv
// growing_interp_signed: linear interpolator that emits 2^K samples between consecutive inputs.
// It is the inverse of the growing-sum averager and uses a one-cycle registered output latency.
module growing_interp_signed #(
    parameter int N        = 16,
    parameter int MAX_LOG2 = 7
) (
    input logic clk,
    input logic rst,
    growing_interp_signed_if.slave bus
);
    localparam int AW = N + MAX_LOG2 + 1;
    localparam int KW = $clog2(MAX_LOG2 + 2);
    localparam int CW = MAX_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;
    state_t state, state_nxt;

    logic signed [N-1:0]  prev;
    logic signed [N:0]    diff;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;
    logic [KW-1:0]        k, k_in;
    logic                 last, accept;

    assign k_in   = bus.n_interp_in > 8'(MAX_LOG2) ? KW'(MAX_LOG2) : bus.n_interp_in[KW-1:0];
    assign last   = cnt == (CW'(1) << k) - CW'(1);
    assign accept = bus.valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb
        state_nxt = state == IDLE ? (accept ? WAIT : IDLE) :
                    accept ? EMIT :
                    (state == EMIT && last) ? WAIT : state;

    always_comb
        bus.in_ready = state != EMIT || last;

    // A new burst overrides the running acc/cnt update on its acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev        <= '0;
            diff        <= '0;
            acc         <= '0;
            cnt         <= '0;
            k           <= '0;
            bus.y       <= '0;
            bus.new_dat <= 1'b0;
        end else begin
            bus.new_dat <= state == EMIT;
            if (state == EMIT) begin
                bus.y <= N'(acc >>> k);
                acc   <= acc + {{(AW-N-1){diff[N]}}, diff};
                cnt   <= cnt + CW'(1);
            end
            if (accept) begin
                prev <= bus.x;
                if (state != IDLE) begin
                    k    <= k_in;
                    diff <= {bus.x[N-1], bus.x} - {prev[N-1], prev};
                    acc  <= {{(AW-N){prev[N-1]}}, prev} <<< k_in;
                    cnt  <= '0;
                end
            end
        end
    end
endmodule
